// File: rtl/dmem_sbuf_if.sv
// MEM-stage to data-memory bus: load/store requests, combinational load data,
// and store-buffer status.
interface dmem_sbuf_if #(
  parameter int unsigned SB_DEPTH = 4
);
  localparam int unsigned CW = $clog2(SB_DEPTH) + 1;

  logic [31:0]   mem_raddr_i;
  logic          rmem_i;
  logic [31:0]   mem_waddr_i;
  logic [31:0]   mem_wdata_i;
  logic          wmem_i;
  logic [31:0]   mem_rdata_o;
  logic          stall_o;
  logic          sb_empty_o;
  logic [CW-1:0] sb_count_o;

  modport master (
    output mem_raddr_i, rmem_i, mem_waddr_i, mem_wdata_i, wmem_i,
    input  mem_rdata_o, stall_o, sb_empty_o, sb_count_o
  );

  modport slave (
    input  mem_raddr_i, rmem_i, mem_waddr_i, mem_wdata_i, wmem_i,
    output mem_rdata_o, stall_o, sb_empty_o, sb_count_o
  );
endinterface

// File: rtl/dmem_sbuf.sv
// Data-memory responder: in-order store buffer draining into a single-port word
// RAM, with same-cycle loads forwarded from the buffer.
module dmem_sbuf #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  dmem_sbuf_if.slave  bus
);
  localparam int unsigned PW        = $clog2(SB_DEPTH);
  localparam int unsigned CW        = PW + 1;
  localparam int unsigned RAM_WORDS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [31:0]       data;
  } sb_entry_t;

  sb_entry_t         sb_q [SB_DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;
  logic [31:0]       ram [RAM_WORDS];

  logic              full_c, empty_c, stall_c, enq_c, deq_c;
  logic [ADDR_W-1:0] ridx_c, widx_c;
  logic              fwd_hit_c;
  logic [31:0]       fwd_data_c;
  logic [PW-1:0]     fwd_ptr_c;

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_raddr_i[31:ADDR_W+2], bus.mem_raddr_i[1:0],
                              bus.mem_waddr_i[31:ADDR_W+2], bus.mem_waddr_i[1:0]};

  assign ridx_c  = bus.mem_raddr_i[ADDR_W+1:2];
  assign widx_c  = bus.mem_waddr_i[ADDR_W+1:2];
  assign full_c  = (count_q == CW'(SB_DEPTH));
  assign empty_c = (count_q == '0);
  assign stall_c = full_c & (bus.rmem_i | bus.wmem_i);
  assign enq_c   = bus.wmem_i & ~stall_c;
  // A load owns the RAM port unless the buffer is full.
  assign deq_c   = ~empty_c & (full_c | ~bus.rmem_i);

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_ptr_c  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      fwd_ptr_c = head_q + PW'(i);
      if ((CW'(i) < count_q) && (sb_q[fwd_ptr_c].idx == ridx_c)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = sb_q[fwd_ptr_c].data;
      end
    end
  end

  assign bus.mem_rdata_o = (bus.rmem_i & ~stall_c) ? (fwd_hit_c ? fwd_data_c : ram[ridx_c])
                                                   : 32'h0;
  assign bus.stall_o     = stall_c;
  assign bus.sb_empty_o  = empty_c;
  assign bus.sb_count_o  = count_q;

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq_c) tail_q <= tail_q + PW'(1);
      if (deq_c) head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(enq_c) - CW'(deq_c);
    end
  end

  // Entry payloads need no reset; occupancy decides validity.
  always_ff @(posedge clk) begin
    if (!rst && enq_c) sb_q[tail_q] <= '{idx: widx_c, data: bus.mem_wdata_i};
  end

  always_ff @(posedge clk) begin
    if (!rst && deq_c) ram[sb_q[head_q].idx] <= sb_q[head_q].data;
  end
endmodule
